// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin arbiter and phase sequencer for a shared
// invalidate-based snoop bus. Grants one transaction at a time (read miss,
// write miss, write back), broadcasts it to all snoopers, runs an optional
// owner-flush phase and a memory phase, then pulses done to the requester.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   req          per-controller request, held until done
//   req_type     per-controller type, slice i = [2i+1:2i] (01 RM, 10 WM, 11 WB)
//   req_addr     per-controller line address, slice i = [i*ADDR_W +: ADDR_W]
//   snoop_hit_wb per-snooper "holds line exclusive" response
//   gnt          one-hot grant for the whole transaction
//   snoop_valid  one-cycle broadcast strobe
//   snoop_type   broadcast transaction type
//   snoop_addr   broadcast line address
//   snoop_src    index of the granted requester
//   flush_gnt    one-hot flush grant to the selected owner
//   done         one-cycle completion pulse to the granted requester
//   busy         high from broadcast through completion
module snoop_bus_arbiter #(
  parameter int NREQ       = 4,
  parameter int SRC_W      = 2,
  parameter int ADDR_W     = 8,
  parameter int MEM_CYCLES = 3,
  parameter int WB_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      req_type,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]        snoop_hit_wb,
  output logic [NREQ-1:0]        gnt,
  output logic                   snoop_valid,
  output logic [1:0]             snoop_type,
  output logic [ADDR_W-1:0]      snoop_addr,
  output logic [SRC_W-1:0]       snoop_src,
  output logic [NREQ-1:0]        flush_gnt,
  output logic [NREQ-1:0]        done,
  output logic                   busy
);

  localparam int CNT_MAX = (MEM_CYCLES > WB_CYCLES) ? MEM_CYCLES : WB_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BCAST, S_SNOOPRESP, S_FLUSH, S_MEM, S_DONE
  } state_t;

  state_t            state, state_d;
  logic [SRC_W-1:0]  ptr, ptr_d;
  logic [CNT_W-1:0]  cnt, cnt_d;

  logic [NREQ-1:0]   gnt_d, flush_d, done_d, hits, elig;
  logic              valid_d, busy_d, found;
  logic [1:0]        type_d;
  logic [ADDR_W-1:0] addr_d;
  logic [SRC_W-1:0]  src_d, win, cand;

  // Eligibility and round-robin pick starting from ptr.
  always_comb begin
    elig  = '0;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = req[i] && (req_type[2*i +: 2] != 2'b00);
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = SRC_W'((32'(ptr) + i) % NREQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    gnt_d   = gnt;
    valid_d = 1'b0;
    type_d  = snoop_type;
    addr_d  = snoop_addr;
    src_d   = snoop_src;
    flush_d = flush_gnt;
    done_d  = '0;
    busy_d  = busy;
    hits    = snoop_hit_wb & ~gnt;
    case (state)
      S_IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          type_d     = req_type[2*win +: 2];
          addr_d     = req_addr[win*ADDR_W +: ADDR_W];
          src_d      = win;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_BCAST;
        end
      end
      S_BCAST: begin
        // A write back is itself the data transfer: skip snoop collection.
        if (snoop_type == 2'b11) begin
          cnt_d   = CNT_W'(WB_CYCLES);
          state_d = S_MEM;
        end else begin
          state_d = S_SNOOPRESP;
        end
      end
      S_SNOOPRESP: begin
        if (hits != '0) begin
          flush_d = hits & (~hits + NREQ'(1));
          cnt_d   = CNT_W'(WB_CYCLES);
          state_d = S_FLUSH;
        end else begin
          cnt_d   = CNT_W'(MEM_CYCLES);
          state_d = S_MEM;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          flush_d = '0;
          cnt_d   = CNT_W'(MEM_CYCLES);
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          // gnt is the one-hot of the winner, so it doubles as the done mask.
          done_d  = gnt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = SRC_W'((32'(snoop_src) + 1) % NREQ);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      gnt         <= '0;
      snoop_valid <= 1'b0;
      snoop_type  <= '0;
      snoop_addr  <= '0;
      snoop_src   <= '0;
      flush_gnt   <= '0;
      done        <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      cnt         <= cnt_d;
      gnt         <= gnt_d;
      snoop_valid <= valid_d;
      snoop_type  <= type_d;
      snoop_addr  <= addr_d;
      snoop_src   <= src_d;
      flush_gnt   <= flush_d;
      done        <= done_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
module tb_snoop_bus_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int MEMC = 3;
  localparam int WBC  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [2*NREQ-1:0] req_type = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]   snoop_hit_wb = '0;
  logic [NREQ-1:0]   gnt, flush_gnt, done;
  logic              snoop_valid, busy;
  logic [1:0]        snoop_type;
  logic [AW-1:0]     snoop_addr;
  logic [1:0]        snoop_src;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;

  always #5 clk = ~clk;

  snoop_bus_arbiter #(
    .NREQ(NREQ), .SRC_W(2), .ADDR_W(AW), .MEM_CYCLES(MEMC), .WB_CYCLES(WBC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_type(req_type), .req_addr(req_addr),
    .snoop_hit_wb(snoop_hit_wb), .gnt(gnt), .snoop_valid(snoop_valid),
    .snoop_type(snoop_type), .snoop_addr(snoop_addr), .snoop_src(snoop_src),
    .flush_gnt(flush_gnt), .done(done), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".flush"}, 32'(flush_gnt), 0);
    chk({tag, ".valid"}, 32'(snoop_valid), 0);
  endtask

  // Called at a negedge while the DUT is idle. Models the transaction from the
  // rules: round-robin winner, phase lengths, owner selection. abort_at > 0
  // pulls reset in that cycle and abandons the transaction.
  task automatic txn(input string tag, input logic [3:0] r, input logic [7:0] ty,
                     input logic [31:0] ad, input logic [3:0] hit, input int abort_at);
    int w, tw, done_t, fl_idx;
    logic [3:0] oh, fl, masked;
    bit flush;
    req = r; req_type = ty; req_addr = ad; snoop_hit_wb = 4'($urandom);
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (ptr_m + k) % NREQ;
      if (w < 0 && r[c] && ty[2*c +: 2] != 2'b00) w = c;
    end
    if (w < 0) begin
      repeat (3) begin
        @(negedge clk);
        chk_quiet({tag, ".noelig"});
      end
      return;
    end
    oh = 4'b0001 << w;
    tw = int'(ty[2*w +: 2]);
    masked = hit & ~oh;
    flush = (tw != 3) && (masked != 4'b0);
    fl_idx = -1;
    for (int k = NREQ - 1; k >= 0; k--) if (masked[k]) fl_idx = k;
    fl = flush ? (4'b0001 << fl_idx) : 4'b0;
    if (tw == 3)    done_t = 2 + WBC;
    else if (flush) done_t = 3 + WBC + MEMC;
    else            done_t = 3 + MEMC;
    for (int t = 1; t <= done_t + 1; t++) begin
      string s;
      @(negedge clk);
      s = $sformatf("%s.t%0d", tag, t);
      chk({s, ".gnt"}, 32'(gnt), (t <= done_t) ? 32'(oh) : 0);
      chk({s, ".busy"}, 32'(busy), (t <= done_t) ? 1 : 0);
      chk({s, ".valid"}, 32'(snoop_valid), (t == 1) ? 1 : 0);
      chk({s, ".done"}, 32'(done), (t == done_t) ? 32'(oh) : 0);
      chk({s, ".flush"}, 32'(flush_gnt), (flush && t >= 3 && t < 3 + WBC) ? 32'(fl) : 0);
      if (t <= done_t) chk({s, ".src"}, 32'(snoop_src), 32'(w));
      if (t == 1) begin
        chk({s, ".type"}, 32'(snoop_type), 32'(tw));
        chk({s, ".addr"}, 32'(snoop_addr), 32'(ad[8*w +: 8]));
      end
      if (t == abort_at) begin
        #2 rst = 1'b0;
        #1 chk_quiet({s, ".rst_now"});
        @(negedge clk);
        chk_quiet({s, ".rst_held"});
        rst = 1'b1;
        ptr_m = 0;
        return;
      end
      // Everything the requester drives after the grant must be ignored.
      if (t == 1) begin
        req = 4'($urandom); req_type = 8'($urandom); req_addr = $urandom;
      end
      snoop_hit_wb = (t == 2) ? hit : 4'($urandom);
    end
    ptr_m = (w + 1) % NREQ;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset.type", 32'(snoop_type), 0);
    chk("reset.addr", 32'(snoop_addr), 0);
    chk("reset.src", 32'(snoop_src), 0);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("post_reset");

    // Read miss, no flush
    txn("rm", 4'b0010, 8'b0000_0100, 32'h0000_5A00, 4'b0000, 0);
    // Write miss with owner flush from line 2
    txn("wm_fl", 4'b0001, 8'b0000_0010, 32'h0000_0033, 4'b0100, 0);
    // Write back ignores all snoop responses
    txn("wb", 4'b0100, 8'b0011_0000, 32'h00C7_0000, 4'b1111, 0);
    // Own bit masked: no flush
    txn("mask", 4'b0010, 8'b0000_0100, 32'h0000_1100, 4'b0010, 0);
    // Type 00 is never eligible
    txn("type00", 4'b1000, 8'b0000_0000, $urandom, 4'($urandom), 0);
    txn("type00b", 4'b1001, 8'b0000_0001, $urandom, 4'($urandom), 0);
    txn("type00c", 4'b1001, 8'b0000_0001, $urandom, 4'($urandom), 0);
    req = '0;

    // Reset mid-flush, then round robin restarts at 0
    txn("abort", 4'b0100, 8'b0001_0000, 32'h0044_0000, 4'b0001, 4);
    req = '0;
    repeat (2) begin
      @(negedge clk);
      chk_quiet("after_abort");
    end
    for (int i = 0; i < 4; i++)
      txn($sformatf("rr%0d", i), 4'b1111, 8'b0110_1101, $urandom, 4'($urandom), 0);
    txn("rr_03a", 4'b1001, 8'b0100_0001, $urandom, 4'b0000, 0);
    txn("rr_03b", 4'b1001, 8'b0100_0001, $urandom, 4'b0000, 0);
    txn("rr_03c", 4'b1001, 8'b0100_0001, $urandom, 4'b0000, 0);

    for (int i = 0; i < 40; i++)
      txn($sformatf("rnd%0d", i), 4'($urandom), 8'($urandom), $urandom, 4'($urandom), 0);

    req = '0;
    @(negedge clk);
    chk_quiet("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared snoop bus that connects NREQ per-line coherence controllers (invalid/shared/exclusive protocol).
- Grants one bus transaction at a time: read miss, write miss or write back.
- Broadcasts the winning transaction to all snoopers and collects their write-back (owner flush) responses.
- Sequences the flush and memory phases, then signals completion to the requester.

Parameters:
- NREQ, 4, number of cache controllers on the bus.
- SRC_W, 2, requester index width; must equal clog2(NREQ).
- ADDR_W, 8, line address width.
- MEM_CYCLES, 3, memory access phase length for read/write miss; minimum 1.
- WB_CYCLES, 2, write-back or flush phase length; minimum 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NREQ  request per controller; held high until its done pulse.
- req_type  in  2*NREQ  per-requester type, slice i = bits [2i+1:2i]: 01 read miss, 10 write miss, 11 write back, 00 no request.
- req_addr  in  NREQ*ADDR_W  per-requester line address, slice i.
- snoop_hit_wb  in  NREQ  snooper i holds the broadcast line exclusive and must flush it.
- gnt  out  NREQ  one-hot grant, held for the whole transaction.
- snoop_valid  out  1  broadcast strobe, exactly 1 cycle per transaction.
- snoop_type  out  2  type of the broadcast transaction.
- snoop_addr  out  ADDR_W  address of the broadcast transaction.
- snoop_src  out  SRC_W  index of the granted requester.
- flush_gnt  out  NREQ  one-hot; high for the full flush phase to the selected owner.
- done  out  NREQ  1-cycle completion pulse to the granted requester.
- busy  out  1  high from the BCAST state through the DONE state inclusive.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE, RR pointer = 0, counter = 0.
  - All outputs = 0.
  - Any in-flight transaction is abandoned; no done pulse is issued.
- Eligibility: eligible[i] = req[i] AND req_type slice i != 00.
- All outputs are registered.
- IDLE:
  - If any requester is eligible, pick the first eligible index scanning ptr, ptr+1, ... modulo NREQ.
  - Register gnt, snoop_type, snoop_addr and snoop_src from the winner; go to BCAST.
  - Otherwise stay in IDLE.
- BCAST (1 cycle):
  - snoop_valid = 1, busy = 1.
  - Type 11 (write back): load counter = WB_CYCLES, go to MEM.
  - Otherwise go to SNOOPRESP.
- SNOOPRESP (1 cycle):
  - Sample hits = snoop_hit_wb AND NOT gnt (the source's own bit is ignored).
  - hits != 0: flush_gnt = lowest set bit of hits, counter = WB_CYCLES, go to FLUSH.
  - Otherwise: counter = MEM_CYCLES, go to MEM.
  - snoop_hit_wb is ignored in every other state.
- FLUSH:
  - flush_gnt held and the counter decrements each cycle.
  - In the last cycle (counter = 1): flush_gnt cleared on exit, counter = MEM_CYCLES, go to MEM.
- MEM:
  - The counter decrements each cycle.
  - In the last cycle (counter = 1): go to DONE.
- DONE (1 cycle):
  - done[winner] = 1 and gnt = 0 on exit.
  - ptr = (winner + 1) mod NREQ; go to IDLE.
- Latency, with t0 = the IDLE cycle in which the request is sampled:
  - Read/write miss, no flush: snoop_valid at t1, done at t3+MEM_CYCLES (t6 at defaults).
  - Miss with flush: done at t3+WB_CYCLES+MEM_CYCLES (t8 at defaults).
  - Write back: done at t2+WB_CYCLES (t4 at defaults).
- Back-to-back transactions: the earliest next grant is sampled in the IDLE cycle after DONE; no bubble beyond that.
- Request changes after grant:
  - req or req_type or req_addr changes after the grant are ignored; the broadcast values are registered copies.
  - If req drops before done, the transaction still completes and done still pulses.
- Starvation: every eligible requester is served within NREQ transactions.

Test Plan:
- Read miss, no flush: reset, then req=0010, type1=01, addr1=0x5A → gnt=0010 and snoop_valid=1 with type 01, addr 0x5A, src 1 at t1; no flush_gnt; done=0010 at t6; busy low at t7.
- Write miss with flush: req0 type 10 addr 0x33; snoop_hit_wb=0100 during SNOOPRESP → flush_gnt=0100 at t3–t4; done=0001 at t8.
- Round robin: all four request after reset → grant order 0,1,2,3. Then requests 0 and 3 pending with ptr=1 after serving 0 → 3 is granted before 0.
- Write back: req2 type 11 → no SNOOPRESP; snoop_hit_wb=1111 has no effect; done=0100 at t4.
- Masking and idle types:
  - Source bit only: req1 read miss with snoop_hit_wb=0010 → no flush, done at t6.
  - Type 00: req3 with type 00 is never granted.
- Reset mid-operation: rst low during FLUSH → gnt, flush_gnt, busy, done all 0 immediately; after release the first grant goes to requester 0.
